// File: rtl/lsu_issue.sv
// ----------------------------------------------------------------------------
// lsu_issue -- consumer end of the load/store issue handshake.
//
// Takes one operand-ready memory op at a time from the LS issue queue, runs it
// on the data-memory port, and for loads broadcasts the read data on the LS
// CDB request port under the op's destination tag. Stores retire locally once
// memory acknowledges them.
//
// Build option:
//   LSU_STORE_CDB_EN  When defined, a store also broadcasts on the CDB
//                     (tag = rdtag, data = 0) after its memory ack, so the ROB
//                     can mark it complete. When undefined, stores never
//                     raise lscdb_valid.
//
// Parameters:
//   DATA_W  data / address width
//   TAG_W   rename tag width
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   issuels_*       offered op (opcode 1=load/0=store, rdtag, addr, data, ready)
//   issuels_done    op accepted this cycle; queue drops the entry at this edge
//   dmem_req/we/addr/wdata  memory request, held stable until dmem_ack
//   dmem_rdata/ack  memory response, sampled at the rising edge
//   lscdb_valid/tag/data    CDB broadcast request, held stable until grant
//   lscdb_grant     arbiter accepts the broadcast this cycle
// ----------------------------------------------------------------------------
module lsu_issue #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              issuels_opcode,
    input  logic [TAG_W-1:0]  issuels_rdtag,
    input  logic [DATA_W-1:0] issuels_addr,
    input  logic [DATA_W-1:0] issuels_data,
    input  logic              issuels_ready,
    output logic              issuels_done,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,

    output logic              lscdb_valid,
    output logic [TAG_W-1:0]  lscdb_tag,
    output logic [DATA_W-1:0] lscdb_data,
    input  logic              lscdb_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_CDB  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Captured op
    logic                r_opcode;
    logic [TAG_W-1:0]    r_rdtag;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    // Value to broadcast (load data, or zero for a store completion)
    logic [DATA_W-1:0]   r_result;

    logic                w_accept;
    logic                w_mem_done;

    // Reset is folded in so done stays low while reset is asserted, even
    // though the state register is already IDLE.
    assign w_accept     = (r_state == ST_IDLE) & issuels_ready & reset;
    assign w_mem_done   = (r_state == ST_MEM) & dmem_ack;
    assign issuels_done = w_accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Op and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opcode <= 1'b0;
            r_rdtag  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_opcode <= issuels_opcode;
                r_rdtag  <= issuels_rdtag;
                r_addr   <= issuels_addr;
                r_wdata  <= issuels_data;
            end
            // Stores load zero so an optional store broadcast carries data=0.
            if (w_mem_done) begin
                r_result <= r_opcode ? dmem_rdata : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        lscdb_valid = 1'b0;
        lscdb_tag   = '0;
        lscdb_data  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_MEM;
                end
            end

            ST_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = ~r_opcode;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                if (dmem_ack) begin
                    if (r_opcode) begin
                        w_state_nxt = ST_CDB;
                    end else begin
`ifdef LSU_STORE_CDB_EN
                        w_state_nxt = ST_CDB;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
            end

            ST_CDB: begin
                lscdb_valid = 1'b1;
                lscdb_tag   = r_rdtag;
                lscdb_data  = r_result;
                if (lscdb_grant) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
